zprize_mul_limb_seq: RTL

Sequencer that computes a full W×W-bit product by streaming LW-bit limbs of operand A through the existing zprize_mul_48 multiplier stage (LW × W per issue) and accumulating the returned partial products. It sits directly around that stage: upstream it drives in0/in1/m_i, and downstream it consumes out0/m_o. The multiplier has no stall input and a fixed but unexposed latency, so this block tags every issue through the metadata lane and is latency-agnostic.

---
 rtl/zprize_msm_pkg.sv | 36 +++
 rtl/zprize_mul_limb_seq_if.sv | 26 ++
 rtl/zprize_mul_limb_seq_acc.sv | 52 +++++
 rtl/zprize_mul_limb_seq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/zprize_msm_pkg.sv
// Shared constants, tag layout and sequencer state encoding for the
// limb-serial multiplier wrapper.
package zprize_msm_pkg;

    localparam int W     = 384;
    localparam int LW    = 48;
    localparam int NL    = W / LW;
    localparam int M     = 32;
    localparam int UW    = 16;
    localparam int FLUSH = 16;

    localparam int IW    = $clog2(NL);
    localparam int CW    = $clog2(FLUSH + 1);

    // Tag field offsets inside the multiplier metadata lane, LSB first.
    localparam int TAG_VALID = 0;
    localparam int TAG_IDX   = 1;
    localparam int TAG_LAST  = 1 + IW;
    localparam int TAG_BITS  = 2 + IW;

    // Packed MSB first, so valid lands on bit TAG_VALID.
    typedef struct packed {
        logic          last;
        logic [IW-1:0] idx;
        logic          valid;
    } mul_tag_t;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/zprize_mul_limb_seq_if.sv
// Job request / result handshake bundle.
interface zprize_mul_limb_seq_if;
    import zprize_msm_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic [UW-1:0]  in_user;

    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_p;
    logic [UW-1:0]  out_user;

    modport slave (
        input  in_valid, in_a, in_b, in_user, out_ready,
        output in_ready, out_valid, out_p, out_user
    );

    modport master (
        output in_valid, in_a, in_b, in_user, out_ready,
        input  in_ready, out_valid, out_p, out_user
    );

endinterface

// File: rtl/zprize_mul_limb_seq_acc.sv
// Accumulate/shift datapath: folds each returned LW x W partial product into
// the running high part and retires the low LW bits into the result.
module zprize_limb_acc
    import zprize_msm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [IW-1:0]     idx_i,
    input  logic              last_i,
    input  logic [LW+W-1:0]   prod_i,
    output logic [2*W-1:0]    res_o,
    output logic              done_o
);

    logic [W-1:0]    acc_hi_q, acc_hi_d;
    logic [2*W-1:0]  res_q, res_d;
    logic [W+LW-1:0] sum;

    // One W+LW adder per return; the sum cannot overflow W+LW bits.
    always_comb begin
        sum      = {{LW{1'b0}}, acc_hi_q} + prod_i;
        acc_hi_d = acc_hi_q;
        res_d    = res_q;
        if (clear_i) begin
            acc_hi_d = '0;
            res_d    = '0;
        end else if (valid_i) begin
            acc_hi_d = sum[W+LW-1:LW];
            res_d[LW*idx_i +: LW] = sum[LW-1:0];
            if (last_i) begin
                res_d[2*W-1 -: W] = sum[W+LW-1:LW];
            end
        end
    end

    // Accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hi_q <= '0;
            res_q    <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            res_q    <= res_d;
        end
    end

    assign res_o  = res_q;
    assign done_o = valid_i & last_i;

endmodule

// File: rtl/zprize_mul_limb_seq.sv
// Streams the limbs of A through the external LW x W multiplier, tagging each
// issue in the metadata lane so the block does not depend on its latency.
//
// state    | meaning
// ST_FLUSH | post-reset quiet period, drains stale multiplier returns
// ST_IDLE  | ready for a job
// ST_ISSUE | one A limb per cycle into the multiplier
// ST_WAIT  | all limbs issued, waiting for the last return
// ST_DONE  | result held on out_p until out_ready
module zprize_mul_limb_seq
    import zprize_msm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    zprize_mul_limb_seq_if.slave  job,
    output logic [LW-1:0]         mul_in0_o,
    output logic [W-1:0]          mul_in1_o,
    output logic [M-1:0]          mul_m_i_o,
    input  logic [M-1:0]          mul_m_o_i,
    input  logic [LW+W-1:0]       mul_out0_i
);

    seq_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  k_q, k_d;
    logic [IW-1:0]  exp_idx_q;
    logic           err_idx_q;
    logic [W-1:0]   a_q, b_q;
    logic [UW-1:0]  user_q;

    logic           load;
    logic           in_ready;
    logic           out_valid;
    mul_tag_t       issue_tag;
    mul_tag_t       ret_tag;
    logic           accept;
    logic           acc_done;
    logic [2*W-1:0] res;
    logic           unused_tag_fill;

    assign ret_tag         = mul_tag_t'(mul_m_o_i[TAG_BITS-1:0]);
    assign unused_tag_fill = |mul_m_o_i[M-1:TAG_BITS];

    // Gating by state keeps stale or X tags from the multiplier pipe out.
    assign accept = ret_tag.valid & ((state_q == ST_ISSUE) | (state_q == ST_WAIT));

    // Sequencer state, flush timer and issue counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FLUSH;
            cnt_q   <= CW'(FLUSH);
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
        end
    end

    // Next-state and issue-side outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_d       = k_q;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        issue_tag = '0;
        mul_in0_o = '0;
        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_IDLE: begin
                in_ready = 1'b1;
                if (job.in_valid) begin
                    load    = 1'b1;
                    k_d     = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_in0_o = a_q[LW*k_q +: LW];
                issue_tag = '{last: (k_q == IW'(NL-1)), idx: k_q, valid: 1'b1};
                k_d       = k_q + 1'b1;
                if (acc_done)                  state_d = ST_DONE;
                else if (k_q == IW'(NL-1))     state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (acc_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (job.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_FLUSH;
        endcase
    end

    // Job operands and user tag, captured on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            user_q <= '0;
        end else if (load) begin
            a_q    <= job.in_a;
            b_q    <= job.in_b;
            user_q <= job.in_user;
        end
    end

    // Return-order tracking; a mismatch is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_idx_q <= '0;
            err_idx_q <= 1'b0;
        end else if (load) begin
            exp_idx_q <= '0;
        end else if (accept) begin
            exp_idx_q <= exp_idx_q + 1'b1;
            if (ret_tag.idx != exp_idx_q) err_idx_q <= 1'b1;
        end
    end

    a_ret_order: assert property (@(posedge clk) disable iff (rst) !err_idx_q);

    zprize_limb_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (load),
        .valid_i (accept),
        .idx_i   (ret_tag.idx),
        .last_i  (ret_tag.last),
        .prod_i  (mul_out0_i),
        .res_o   (res),
        .done_o  (acc_done)
    );

    assign mul_in1_o     = b_q;
    assign mul_m_i_o     = {{(M-TAG_BITS){1'b0}}, issue_tag};
    assign job.in_ready  = in_ready;
    assign job.out_valid = out_valid;
    assign job.out_p     = res;
    assign job.out_user  = user_q;

endmodule
